uart_rx_frame_buffer: RTL and testbench

Receive-side frame buffer directly downstream of the `Duplex` UART. It detects each completed receive frame on `rx_done_flag` and captures `data_out` and `error_flag` into a show-ahead FIFO. It keeps saturating parity and framing error counters, and raises a sticky overflow flag. The host-side consumer drains received bytes at its own pace instead of racing each `rx_done_flag`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 71 +++++++
 rtl/uart_rx_frame_buffer.sv | 119 +++++++++++
 tb/tb_uart_rx_frame_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: error-bit positions and the receive entry layout
// used by both the RX frame buffer and the TX-side path.
package uart_pkg;

   localparam int ERR_PARITY = 0;
   localparam int ERR_START  = 1;
   localparam int ERR_STOP   = 2;

   localparam int DATA_W = 8;
   localparam int ERR_W  = 3;

   // One received frame: error flags above the data byte.
   typedef struct packed {
      logic [ERR_W-1:0]  err;
      logic [DATA_W-1:0] data;
   } rx_entry_t;

   // A framing problem is either a bad start bit or a bad stop bit.
   function automatic logic is_frame_err(input logic [ERR_W-1:0] e);
      return e[ERR_START] | e[ERR_STOP];
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that
// full (MSBs differ, rest equal) and empty (all equal) are unambiguous.
// A write while full is accepted only when a pop happens in the same cycle.
// Handshake: a write happens when wr_en_i is high and there is room (or a
// simultaneous pop frees one); a pop happens when rd_en_i is high and the
// FIFO is non-empty. clear_i overrides both and empties the FIFO.
module uart_sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_wr;
   logic             do_rd;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;

   assign do_rd = rd_en_i & ~empty_o & ~clear_i;
   assign do_wr = wr_en_i & (~full_o | do_rd) & ~clear_i;

   // Head is visible without a register stage; zero when nothing is stored.
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values, clear taking priority over any traffic.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since empty masks the head.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Receive-side frame buffer behind the Duplex UART. Detects each rising
// edge of rx_done_flag, queues {error, data} into a show-ahead FIFO, keeps
// saturating parity/framing error counters and a sticky overflow flag.
module uart_rx_frame_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       rx_done_flag,
   input  logic [7:0]                 rx_data,
   input  logic [2:0]                 rx_error,
   input  logic                       drop_errored,
   input  logic                       clear,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic [7:0]                 rd_data,
   output logic [2:0]                 rd_err,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [ERR_CNT_W-1:0]       parity_err_cnt,
   output logic [ERR_CNT_W-1:0]       frame_err_cnt
);

   logic                 s1_q, s2_q, s3_q;
   logic                 capture;
   logic                 store;
   logic                 push_req;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 overflow_q, overflow_d;
   logic [ERR_CNT_W-1:0] par_cnt_q, par_cnt_d;
   logic [ERR_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
   rx_entry_t            wr_entry;
   rx_entry_t            head_entry;

   // One event per rising edge of the synchronized done level.
   assign capture  = s2_q & ~s3_q;
   assign store    = ~(drop_errored & (|rx_error));
   assign push_req = capture & store & ~clear;
   assign pop      = rd_en & ~fifo_empty & ~clear;

   assign wr_entry.err  = rx_error;
   assign wr_entry.data = rx_data;

   // Two-flop synchronizer plus history flop; clear deliberately leaves
   // these alone so a level that is still high does not fire again.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= rx_done_flag;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Overflow and error counter next-state; counters stick at all-ones.
   always_comb begin
      overflow_d = overflow_q;
      par_cnt_d  = par_cnt_q;
      frm_cnt_d  = frm_cnt_q;
      if (clear) begin
         overflow_d = 1'b0;
         par_cnt_d  = '0;
         frm_cnt_d  = '0;
      end else if (capture) begin
         if (rx_error[ERR_PARITY] && (par_cnt_q != '1))
            par_cnt_d = par_cnt_q + ERR_CNT_W'(1);
         if (is_frame_err(rx_error) && (frm_cnt_q != '1))
            frm_cnt_d = frm_cnt_q + ERR_CNT_W'(1);
         // A frame is lost only when full and no pop frees a slot.
         if (push_req && fifo_full && !pop)
            overflow_d = 1'b1;
      end
   end

   // Status registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q <= 1'b0;
         par_cnt_q  <= '0;
         frm_cnt_q  <= '0;
      end else begin
         overflow_q <= overflow_d;
         par_cnt_q  <= par_cnt_d;
         frm_cnt_q  <= frm_cnt_d;
      end
   end

   uart_sync_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .clear_i   (clear),
      .wr_en_i   (push_req),
      .wr_data_i (wr_entry),
      .rd_en_i   (rd_en),
      .rd_data_o (head_entry),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (level)
   );

   assign rd_valid       = ~fifo_empty;
   assign rd_data        = head_entry.data;
   assign rd_err         = head_entry.err;
   assign overflow       = overflow_q;
   assign parity_err_cnt = par_cnt_q;
   assign frame_err_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Directed and randomized checks of uart_rx_frame_buffer against a
// queue-based reference model.
module tb_uart_rx_frame_buffer;

   localparam int DEPTH = 8;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clock;
   logic          reset_n;
   logic          rx_done_flag;
   logic [7:0]    rx_data;
   logic [2:0]    rx_error;
   logic          drop_errored;
   logic          clear;
   logic          rd_en;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic [2:0]    rd_err;
   logic [3:0]    level;
   logic          overflow;
   logic [CW-1:0] parity_err_cnt;
   logic [CW-1:0] frame_err_cnt;

   int tests = 0;
   int fails = 0;

   // Reference model: queue of {err, data}, sticky overflow, counters.
   logic [10:0] exp_q[$];
   int          m_par;
   int          m_frm;
   int          m_ovf;

   uart_rx_frame_buffer #(.DEPTH(DEPTH), .ERR_CNT_W(CW)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .rx_done_flag   (rx_done_flag),
      .rx_data        (rx_data),
      .rx_error       (rx_error),
      .drop_errored   (drop_errored),
      .clear          (clear),
      .rd_en          (rd_en),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .rd_err         (rd_err),
      .level          (level),
      .overflow       (overflow),
      .parity_err_cnt (parity_err_cnt),
      .frame_err_cnt  (frame_err_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_par = 0;
      m_frm = 0;
      m_ovf = 0;
   endtask

   // What the buffer should do with one completed frame.
   task automatic model_frame(input logic [7:0] d, input logic [2:0] e, input logic drp);
      if (e[0] && m_par < CMAX) m_par++;
      if ((e[1] || e[2]) && m_frm < CMAX) m_frm++;
      if (!(drp && e != 3'b000)) begin
         if (exp_q.size() < DEPTH) exp_q.push_back({e, d});
         else m_ovf = 1;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, rd_valid, (exp_q.size() > 0));
      check({tag, ".level"}, level, exp_q.size());
      check({tag, ".ovf"}, overflow, m_ovf);
      check({tag, ".par"}, parity_err_cnt, m_par);
      check({tag, ".frm"}, frame_err_cnt, m_frm);
      if (exp_q.size() > 0) begin
         check({tag, ".data"}, rd_data, exp_q[0][7:0]);
         check({tag, ".err"}, rd_err, exp_q[0][10:8]);
      end
   endtask

   // Raise the done level; returns after edges k and k+1, before k+2.
   task automatic frame_start(input logic [7:0] d, input logic [2:0] e, input logic drp);
      @(negedge clock);
      rx_data      = d;
      rx_error     = e;
      drop_errored = drp;
      rx_done_flag = 1'b1;
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic frame_end();
      rx_done_flag = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [2:0] e, input logic drp, input int hold);
      frame_start(d, e, drp);
      repeat (hold) @(negedge clock);
      frame_end();
      model_frame(d, e, drp);
   endtask

   // Pop one entry (or attempt one on an empty FIFO) and check the result.
   task automatic pop_one(input string tag);
      if (exp_q.size() > 0) begin
         check({tag, ".head"}, {rd_err, rd_data}, exp_q[0]);
      end
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check_all(tag);
   endtask

   initial begin
      logic [7:0] last_byte;
      reset_n      = 1'b0;
      rx_done_flag = 1'b0;
      rx_data      = '0;
      rx_error     = '0;
      drop_errored = 1'b0;
      clear        = 1'b0;
      rd_en        = 1'b0;
      model_reset();

      #1;
      check("rst.valid", rd_valid, 0);
      check("rst.level", level, 0);
      check("rst.ovf", overflow, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_all("after_reset");

      // Basic capture: long high level, one entry, 3-edge latency.
      frame_start(8'hAA, 3'b000, 1'b0);
      check("lat.level_k1", level, 0);
      check("lat.valid_k1", rd_valid, 0);
      @(negedge clock);
      check("lat.level_k2", level, 1);
      check("lat.data_k2", rd_data, 8'hAA);
      repeat (47) @(negedge clock);
      frame_end();
      model_frame(8'hAA, 3'b000, 1'b0);
      check_all("basic");
      pop_one("basic_pop");

      // Error counting and dropping of errored frames.
      send_frame(8'h55, 3'b101, 1'b0, 3);
      send_frame(8'h0F, 3'b100, 1'b1, 3);
      check("err.par", parity_err_cnt, 1);
      check("err.frm", frame_err_cnt, 2);
      check("err.level", level, 1);
      check("err.rd_err", rd_err, 3'b101);
      check_all("err");
      pop_one("err_pop");

      // Overflow: nine frames into eight slots.
      for (int i = 0; i < 9; i++) send_frame(8'(i), 3'b000, 1'b0, 3);
      check("ovf.level", level, 8);
      check("ovf.flag", overflow, 1);
      check_all("ovf");
      for (int i = 0; i < 8; i++) begin
         check("ovf.order", rd_data, i);
         pop_one("ovf_drain");
      end
      check("ovf.empty", rd_valid, 0);

      // Clear on a capture edge discards the frame and zeroes status.
      send_frame(8'h33, 3'b011, 1'b0, 3);
      frame_start(8'h44, 3'b001, 1'b0);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      model_reset();
      check_all("clear");
      repeat (10) @(negedge clock);
      check("clear.no_retrig", level, 0);
      frame_end();
      check_all("clear_after");

      // Pop and capture on the same edge while full.
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 3'b000, 1'b0, 3);
      check_all("full");
      frame_start(8'hC3, 3'b000, 1'b0);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back({3'b000, 8'hC3});
      check("simul.level", level, 8);
      check("simul.ovf", overflow, 0);
      check("simul.head", rd_data, 8'h11);
      frame_end();
      last_byte = 8'h00;
      while (exp_q.size() > 0) begin
         last_byte = rd_data;
         pop_one("simul_drain");
      end
      check("simul.last", last_byte, 8'hC3);

      // Counter saturation with a 2-bit counter.
      for (int i = 0; i < 5; i++) send_frame(8'h01, 3'b001, 1'b1, 3);
      check("sat.par", parity_err_cnt, 3);
      check_all("sat");

      // Asynchronous reset with entries stored.
      for (int i = 0; i < 3; i++) send_frame(8'h20 + 8'(i), 3'b000, 1'b0, 3);
      check("arst.pre_level", level, 3);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("arst.valid", rd_valid, 0);
      check("arst.data", rd_data, 0);
      check("arst.err", rd_err, 0);
      check("arst.level", level, 0);
      check("arst.ovf", overflow, 0);
      check("arst.par", parity_err_cnt, 0);
      check("arst.frm", frame_err_cnt, 0);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      send_frame(8'hBE, 3'b000, 1'b0, 3);
      check("arst.be", rd_data, 8'hBE);
      check_all("arst_after");
      pop_one("arst_pop");

      // Randomized frames and pops against the model.
      for (int n = 0; n < 60; n++) begin
         logic [7:0] d;
         logic [2:0] e;
         logic       drp;
         int         npop;
         d    = 8'($urandom_range(0, 255));
         e    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         drp  = 1'($urandom_range(0, 1));
         send_frame(d, e, drp, $urandom_range(3, 6));
         check_all("rnd");
         npop = $urandom_range(0, 2);
         for (int p = 0; p < npop; p++) pop_one("rnd_pop");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
